// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port memory bus arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_WAIT,
    ARB_RESP
  } arb_state_e;

  typedef enum logic {
    GNT_I,
    GNT_D
  } arb_gnt_e;

  localparam logic [1:0] FETCH_SIZE = 2'd2;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Fetch, data and downstream memory signals shared by the arbiter and its environment.
// slave = arbiter side, master = core/memory side.
interface mem_bus_arbiter_if;

  logic [63:0] ib_addr;
  logic        ib_en;
  logic        ib_ready;
  logic [31:0] ib_rdata;
  logic        ib_valid;
  logic        ib_acc_err;

  logic [63:0] db_addr;
  logic [1:0]  db_size;
  logic        db_en;
  logic        db_write;
  logic [63:0] db_wdata;
  logic        db_ready;
  logic [63:0] db_rdata;
  logic        db_valid;
  logic        db_acc_err;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_addr;
  logic [1:0]  mem_size;
  logic        mem_write;
  logic [63:0] mem_wdata;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;
  logic        mem_resp_err;

  modport slave (
    input  ib_addr, ib_en, ib_ready,
    output ib_rdata, ib_valid, ib_acc_err,
    input  db_addr, db_size, db_en, db_write, db_wdata, db_ready,
    output db_rdata, db_valid, db_acc_err,
    output mem_req_valid, mem_addr, mem_size, mem_write, mem_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
  );

  modport master (
    output ib_addr, ib_en, ib_ready,
    input  ib_rdata, ib_valid, ib_acc_err,
    output db_addr, db_size, db_en, db_write, db_wdata, db_ready,
    input  db_rdata, db_valid, db_acc_err,
    input  mem_req_valid, mem_addr, mem_size, mem_write, mem_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
  );

endinterface

// File: rtl/mem_arb_picker.sv
// Winner select between fetch and data requests.
// ARB_RR_EN: round-robin on ties via a last-granted pointer; otherwise data has fixed priority.
module mem_arb_picker
  import mem_arb_pkg::*;
(
`ifdef ARB_RR_EN
  input  logic     clk,
  input  logic     rst_n,
  input  logic     take,
`endif
  input  logic     ib_en,
  input  logic     db_en,
  output arb_gnt_e pick
);

`ifdef ARB_RR_EN
  arb_gnt_e last_q;

  // Pointer starts at I so the first tie after reset goes to D.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= GNT_I;
    end else if (take) begin
      last_q <= pick;
    end
  end

  always_comb begin
    pick = GNT_I;
    if (ib_en && db_en) begin
      pick = (last_q == GNT_I) ? GNT_D : GNT_I;
    end else if (db_en) begin
      pick = GNT_D;
    end
  end
`else
  always_comb begin
    pick = GNT_I;
    if (db_en) begin
      pick = GNT_D;
    end
  end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one downstream memory port between fetch and data ports, one transaction at a time.
// ARB_RR_EN selects round-robin arbitration instead of data-first fixed priority.
module mem_bus_arbiter
  import mem_arb_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  mem_bus_arbiter_if.slave bus
);

  arb_state_e  state_q, state_d;
  arb_gnt_e    gnt_q, pick;
  logic        take;
  logic        gnt_ready;
  logic [63:0] addr_q;
  logic [1:0]  size_q;
  logic        write_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic        err_q;
  logic        busy_i, busy_d, resp_i, resp_d;

  assign take      = (state_q == ARB_IDLE) && (bus.ib_en || bus.db_en);
  assign gnt_ready = (gnt_q == GNT_I) ? bus.ib_ready : bus.db_ready;

  mem_arb_picker u_picker (
`ifdef ARB_RR_EN
    .clk   (clk),
    .rst_n (rst_n),
    .take  (take),
`endif
    .ib_en (bus.ib_en),
    .db_en (bus.db_en),
    .pick  (pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (take)               state_d = ARB_REQ;
      ARB_REQ:  if (bus.mem_req_ready)  state_d = ARB_WAIT;
      ARB_WAIT: if (bus.mem_resp_valid) state_d = ARB_RESP;
      ARB_RESP: if (gnt_ready)          state_d = ARB_IDLE;
      default:                          state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q   <= GNT_I;
      addr_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (take) begin
        gnt_q <= pick;
        if (pick == GNT_D) begin
          addr_q  <= bus.db_addr;
          size_q  <= bus.db_size;
          write_q <= bus.db_write;
          wdata_q <= bus.db_wdata;
        end else begin
          addr_q  <= bus.ib_addr;
          size_q  <= FETCH_SIZE;
          write_q <= 1'b0;
          wdata_q <= '0;
        end
      end
      if ((state_q == ARB_WAIT) && bus.mem_resp_valid) begin
        rdata_q <= bus.mem_resp_rdata;
        err_q   <= bus.mem_resp_err;
      end
    end
  end

  assign busy_i = (state_q != ARB_IDLE) && (gnt_q == GNT_I);
  assign busy_d = (state_q != ARB_IDLE) && (gnt_q == GNT_D);
  assign resp_i = (state_q == ARB_RESP) && (gnt_q == GNT_I);
  assign resp_d = (state_q == ARB_RESP) && (gnt_q == GNT_D);

  // Valid is forced low while reset is asserted, otherwise "not busy" reads as !en.
  assign bus.ib_valid   = rst_n && (resp_i || (!busy_i && !bus.ib_en));
  assign bus.db_valid   = rst_n && (resp_d || (!busy_d && !bus.db_en));
  assign bus.ib_acc_err = resp_i && err_q;
  assign bus.db_acc_err = resp_d && err_q;
  assign bus.ib_rdata   = addr_q[2] ? rdata_q[63:32] : rdata_q[31:0];
  assign bus.db_rdata   = rdata_q;

  assign bus.mem_req_valid = (state_q == ARB_REQ);
  assign bus.mem_addr      = addr_q;
  assign bus.mem_size      = size_q;
  assign bus.mem_write     = write_q;
  assign bus.mem_wdata     = wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (honours ARB_RR_EN for tie ordering).
module tb_mem_bus_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // Called in REQ at a negedge; returns at a negedge with the arbiter in RESP.
  task automatic serve_txn(input logic [63:0] rd, input logic err);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = rd;
    bus.mem_resp_err   = err;
    tick();
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_err   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ib_addr = '0; bus.ib_en = 1'b0; bus.ib_ready = 1'b0;
    bus.db_addr = '0; bus.db_size = '0; bus.db_en = 1'b0; bus.db_write = 1'b0;
    bus.db_wdata = '0; bus.db_ready = 1'b0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_rdata = '0; bus.mem_resp_err = 1'b0;
    #1;
    checks++; if (bus.ib_valid !== 1'b0) begin failures++; $display("FAIL reset_ib_valid got=%0h exp=0", bus.ib_valid); end
    checks++; if (bus.db_valid !== 1'b0) begin failures++; $display("FAIL reset_db_valid got=%0h exp=0", bus.db_valid); end
    checks++; if (bus.mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%0h exp=0", bus.mem_req_valid); end
    checks++; if (bus.mem_addr !== 64'h0) begin failures++; $display("FAIL reset_mem_addr got=%0h exp=0", bus.mem_addr); end
    checks++; if (bus.db_rdata !== 64'h0) begin failures++; $display("FAIL reset_db_rdata got=%0h exp=0", bus.db_rdata); end
    tick(); tick();
    rst_n = 1'b1;
    #1;
    checks++; if (bus.ib_valid !== 1'b1) begin failures++; $display("FAIL release_ib_valid got=%0h exp=1", bus.ib_valid); end
    checks++; if (bus.db_valid !== 1'b1) begin failures++; $display("FAIL release_db_valid got=%0h exp=1", bus.db_valid); end
  endtask

  task automatic test_fetch();
    tick();
    bus.ib_addr = 64'h8000_0004; bus.ib_en = 1'b1;
    #1;
    checks++; if (bus.ib_valid !== 1'b0) begin failures++; $display("FAIL fetch_idle_valid got=%0h exp=0", bus.ib_valid); end
    tick();
    checks++; if (bus.mem_req_valid !== 1'b1) begin failures++; $display("FAIL fetch_req_valid got=%0h exp=1", bus.mem_req_valid); end
    checks++; if (bus.mem_addr !== 64'h8000_0004) begin failures++; $display("FAIL fetch_addr got=%0h exp=80000004", bus.mem_addr); end
    checks++; if (bus.mem_size !== 2'd2) begin failures++; $display("FAIL fetch_size got=%0h exp=2", bus.mem_size); end
    checks++; if (bus.mem_write !== 1'b0) begin failures++; $display("FAIL fetch_write got=%0h exp=0", bus.mem_write); end
    checks++; if (bus.mem_wdata !== 64'h0) begin failures++; $display("FAIL fetch_wdata got=%0h exp=0", bus.mem_wdata); end
    serve_txn(64'h1111_2222_3333_4444, 1'b0);
    checks++; if (bus.ib_valid !== 1'b1) begin failures++; $display("FAIL fetch_resp_valid got=%0h exp=1", bus.ib_valid); end
    checks++; if (bus.ib_rdata !== 32'h1111_2222) begin failures++; $display("FAIL fetch_rdata got=%0h exp=11112222", bus.ib_rdata); end
    checks++; if (bus.ib_acc_err !== 1'b0) begin failures++; $display("FAIL fetch_err got=%0h exp=0", bus.ib_acc_err); end
    checks++; if (bus.db_valid !== 1'b1) begin failures++; $display("FAIL fetch_db_idle got=%0h exp=1", bus.db_valid); end
    tick();
    checks++; if (bus.ib_valid !== 1'b1) begin failures++; $display("FAIL fetch_hold_valid got=%0h exp=1", bus.ib_valid); end
    bus.ib_ready = 1'b1; bus.ib_en = 1'b0;
    tick();
    bus.ib_ready = 1'b0;
    checks++; if (bus.mem_req_valid !== 1'b0) begin failures++; $display("FAIL fetch_done_req got=%0h exp=0", bus.mem_req_valid); end
    checks++; if (bus.ib_valid !== 1'b1) begin failures++; $display("FAIL fetch_done_valid got=%0h exp=1", bus.ib_valid); end
  endtask

  task automatic test_tie();
    bus.ib_addr = 64'h8000_0008; bus.db_addr = 64'h8000_1000; bus.db_size = 2'd3; bus.db_write = 1'b0;
    bus.ib_en = 1'b1; bus.db_en = 1'b1;
    tick();
    checks++; if (bus.mem_addr !== 64'h8000_1000) begin failures++; $display("FAIL tie1_grant_d got=%0h exp=80001000", bus.mem_addr); end
    checks++; if (bus.mem_size !== 2'd3) begin failures++; $display("FAIL tie1_size got=%0h exp=3", bus.mem_size); end
    checks++; if (bus.ib_valid !== 1'b0) begin failures++; $display("FAIL tie1_ib_wait got=%0h exp=0", bus.ib_valid); end
    checks++; if (bus.db_valid !== 1'b0) begin failures++; $display("FAIL tie1_db_busy got=%0h exp=0", bus.db_valid); end
    serve_txn(64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
    checks++; if (bus.db_valid !== 1'b1) begin failures++; $display("FAIL tie1_db_valid got=%0h exp=1", bus.db_valid); end
    checks++; if (bus.db_rdata !== 64'hAAAA_BBBB_CCCC_DDDD) begin failures++; $display("FAIL tie1_db_rdata got=%0h exp=aaaabbbbccccdddd", bus.db_rdata); end
    checks++; if (bus.ib_valid !== 1'b0) begin failures++; $display("FAIL tie1_ib_still got=%0h exp=0", bus.ib_valid); end
    // New data request keeps db_en high, forcing a second tie.
    bus.db_ready = 1'b1; bus.db_addr = 64'h8000_1008;
    tick();
    bus.db_ready = 1'b0;
    tick();
`ifdef ARB_RR_EN
    checks++; if (bus.mem_addr !== 64'h8000_0008) begin failures++; $display("FAIL tie2_grant_i got=%0h exp=80000008", bus.mem_addr); end
    serve_txn(64'h5555_6666_7777_8888, 1'b0);
    checks++; if (bus.ib_rdata !== 32'h7777_8888) begin failures++; $display("FAIL tie2_ib_rdata got=%0h exp=77778888", bus.ib_rdata); end
    checks++; if (bus.db_valid !== 1'b0) begin failures++; $display("FAIL tie2_db_wait got=%0h exp=0", bus.db_valid); end
    bus.ib_ready = 1'b1; bus.ib_en = 1'b0;
    tick();
    bus.ib_ready = 1'b0;
    tick();
    checks++; if (bus.mem_addr !== 64'h8000_1008) begin failures++; $display("FAIL tie3_grant_d got=%0h exp=80001008", bus.mem_addr); end
    serve_txn(64'h0123_4567_89AB_CDEF, 1'b0);
    checks++; if (bus.db_rdata !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("FAIL tie3_db_rdata got=%0h exp=0123456789abcdef", bus.db_rdata); end
    bus.db_ready = 1'b1; bus.db_en = 1'b0;
    tick();
    bus.db_ready = 1'b0;
`else
    checks++; if (bus.mem_addr !== 64'h8000_1008) begin failures++; $display("FAIL tie2_grant_d got=%0h exp=80001008", bus.mem_addr); end
    serve_txn(64'h0123_4567_89AB_CDEF, 1'b0);
    checks++; if (bus.db_rdata !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("FAIL tie2_db_rdata got=%0h exp=0123456789abcdef", bus.db_rdata); end
    checks++; if (bus.ib_valid !== 1'b0) begin failures++; $display("FAIL tie2_ib_wait got=%0h exp=0", bus.ib_valid); end
    bus.db_ready = 1'b1; bus.db_en = 1'b0;
    tick();
    bus.db_ready = 1'b0;
    tick();
    checks++; if (bus.mem_addr !== 64'h8000_0008) begin failures++; $display("FAIL tie3_grant_i got=%0h exp=80000008", bus.mem_addr); end
    checks++; if (bus.mem_size !== 2'd2) begin failures++; $display("FAIL tie3_size got=%0h exp=2", bus.mem_size); end
    serve_txn(64'h5555_6666_7777_8888, 1'b0);
    checks++; if (bus.ib_rdata !== 32'h7777_8888) begin failures++; $display("FAIL tie3_ib_rdata got=%0h exp=77778888", bus.ib_rdata); end
    bus.ib_ready = 1'b1; bus.ib_en = 1'b0;
    tick();
    bus.ib_ready = 1'b0;
`endif
  endtask

  task automatic test_store();
    bus.db_addr = 64'h8000_2000; bus.db_size = 2'd3; bus.db_write = 1'b1;
    bus.db_wdata = 64'hDEAD_BEEF_0000_0001; bus.db_en = 1'b1;
    tick();
    bus.db_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.mem_req_valid !== 1'b1) begin failures++; $display("FAIL store_req_valid[%0d] got=%0h exp=1", i, bus.mem_req_valid); end
      checks++; if (bus.mem_write !== 1'b1) begin failures++; $display("FAIL store_write[%0d] got=%0h exp=1", i, bus.mem_write); end
      checks++; if (bus.mem_wdata !== 64'hDEAD_BEEF_0000_0001) begin failures++; $display("FAIL store_wdata[%0d] got=%0h exp=deadbeef00000001", i, bus.mem_wdata); end
      checks++; if (bus.mem_addr !== 64'h8000_2000) begin failures++; $display("FAIL store_addr[%0d] got=%0h exp=80002000", i, bus.mem_addr); end
      checks++; if (bus.mem_size !== 2'd3) begin failures++; $display("FAIL store_size[%0d] got=%0h exp=3", i, bus.mem_size); end
      tick();
    end
    serve_txn(64'h0, 1'b0);
    checks++; if (bus.db_valid !== 1'b1) begin failures++; $display("FAIL store_resp_valid got=%0h exp=1", bus.db_valid); end
    bus.db_ready = 1'b1; bus.db_en = 1'b0; bus.db_write = 1'b0;
    tick();
    bus.db_ready = 1'b0;
  endtask

  task automatic test_fault();
    bus.ib_addr = 64'h8000_0010; bus.ib_en = 1'b1;
    tick();
    serve_txn(64'hCAFE_F00D_1234_5678, 1'b1);
    checks++; if (bus.ib_acc_err !== 1'b1) begin failures++; $display("FAIL fault_ib_err got=%0h exp=1", bus.ib_acc_err); end
    checks++; if (bus.ib_valid !== 1'b1) begin failures++; $display("FAIL fault_ib_valid got=%0h exp=1", bus.ib_valid); end
    checks++; if (bus.db_valid !== 1'b1) begin failures++; $display("FAIL fault_db_valid got=%0h exp=1", bus.db_valid); end
    checks++; if (bus.db_acc_err !== 1'b0) begin failures++; $display("FAIL fault_db_err got=%0h exp=0", bus.db_acc_err); end
    bus.ib_ready = 1'b1; bus.ib_en = 1'b0;
    tick();
    bus.ib_ready = 1'b0;
    checks++; if (bus.ib_acc_err !== 1'b0) begin failures++; $display("FAIL fault_err_clear got=%0h exp=0", bus.ib_acc_err); end
  endtask

  task automatic test_en_drop();
    bus.ib_addr = 64'h8000_0004; bus.ib_en = 1'b1;
    tick();
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0; bus.ib_en = 1'b0;
    #1;
    checks++; if (bus.ib_valid !== 1'b0) begin failures++; $display("FAIL endrop_wait_valid got=%0h exp=0", bus.ib_valid); end
    tick();
    checks++; if (bus.ib_valid !== 1'b0) begin failures++; $display("FAIL endrop_wait2_valid got=%0h exp=0", bus.ib_valid); end
    bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 64'h9999_8888_7777_6666;
    tick();
    bus.mem_resp_valid = 1'b0;
    checks++; if (bus.ib_valid !== 1'b1) begin failures++; $display("FAIL endrop_resp_valid got=%0h exp=1", bus.ib_valid); end
    checks++; if (bus.ib_rdata !== 32'h9999_8888) begin failures++; $display("FAIL endrop_rdata got=%0h exp=99998888", bus.ib_rdata); end
    tick();
    checks++; if (bus.ib_valid !== 1'b1) begin failures++; $display("FAIL endrop_hold got=%0h exp=1", bus.ib_valid); end
    bus.ib_ready = 1'b1;
    tick();
    bus.ib_ready = 1'b0;
    checks++; if (bus.mem_req_valid !== 1'b0) begin failures++; $display("FAIL endrop_idle_req got=%0h exp=0", bus.mem_req_valid); end
    tick();
    checks++; if (bus.mem_req_valid !== 1'b0) begin failures++; $display("FAIL endrop_no_reissue got=%0h exp=0", bus.mem_req_valid); end
  endtask

  task automatic test_reset_mid_wait();
    bus.db_addr = 64'h8000_3000; bus.db_size = 2'd3; bus.db_write = 1'b1;
    bus.db_wdata = 64'h1234_5678_9ABC_DEF0; bus.db_en = 1'b1;
    tick();
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    rst_n = 1'b0; bus.db_en = 1'b0; bus.db_write = 1'b0;
    #1;
    checks++; if (bus.mem_req_valid !== 1'b0) begin failures++; $display("FAIL rstw_req_valid got=%0h exp=0", bus.mem_req_valid); end
    checks++; if (bus.mem_addr !== 64'h0) begin failures++; $display("FAIL rstw_addr got=%0h exp=0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 64'h0) begin failures++; $display("FAIL rstw_wdata got=%0h exp=0", bus.mem_wdata); end
    checks++; if (bus.mem_write !== 1'b0) begin failures++; $display("FAIL rstw_write got=%0h exp=0", bus.mem_write); end
    checks++; if (bus.mem_size !== 2'd0) begin failures++; $display("FAIL rstw_size got=%0h exp=0", bus.mem_size); end
    checks++; if (bus.db_valid !== 1'b0) begin failures++; $display("FAIL rstw_db_valid got=%0h exp=0", bus.db_valid); end
    checks++; if (bus.ib_valid !== 1'b0) begin failures++; $display("FAIL rstw_ib_valid got=%0h exp=0", bus.ib_valid); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (bus.db_valid !== 1'b1) begin failures++; $display("FAIL rstw_release_db got=%0h exp=1", bus.db_valid); end
    bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    bus.mem_resp_valid = 1'b0;
    checks++; if (bus.db_valid !== 1'b1) begin failures++; $display("FAIL rstw_late_db_valid got=%0h exp=1", bus.db_valid); end
    checks++; if (bus.db_rdata !== 64'h0) begin failures++; $display("FAIL rstw_late_rdata got=%0h exp=0", bus.db_rdata); end
    checks++; if (bus.mem_req_valid !== 1'b0) begin failures++; $display("FAIL rstw_late_req got=%0h exp=0", bus.mem_req_valid); end
    bus.ib_addr = 64'h8000_0000; bus.ib_en = 1'b1;
    tick();
    checks++; if (bus.mem_req_valid !== 1'b1) begin failures++; $display("FAIL rstw_next_req got=%0h exp=1", bus.mem_req_valid); end
    checks++; if (bus.mem_addr !== 64'h8000_0000) begin failures++; $display("FAIL rstw_next_addr got=%0h exp=80000000", bus.mem_addr); end
    serve_txn(64'h0000_0001_0000_0002, 1'b0);
    checks++; if (bus.ib_rdata !== 32'h0000_0002) begin failures++; $display("FAIL rstw_next_rdata got=%0h exp=2", bus.ib_rdata); end
    bus.ib_ready = 1'b1; bus.ib_en = 1'b0;
    tick();
    bus.ib_ready = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_fetch();
    test_tie();
    test_store();
    test_fault();
    test_en_drop();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares a single downstream memory port between the core's instruction-fetch port (inst_bus semantics) and data-access port (data_bus semantics, non-AMO). Sits between the pipeline and the unified L2/uncached memory port in single-port configurations. Exactly one transaction is outstanding at a time, tracked by a four-state FSM. Data has priority by default; round-robin fairness is a compile-time option.

## Interface
Parameters: none (all widths fixed: 64-bit address and data).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ib_addr  in  64  fetch address, 4-byte aligned
- ib_en  in  1  fetch request, held until completed
- ib_ready  in  1  core accepts fetch response
- ib_rdata  out  32  fetched instruction word
- ib_valid  out  1  fetch response held, or port not busy
- ib_acc_err  out  1  access fault, qualified by ib_valid
- db_addr  in  64  data address
- db_size  in  2  0:1B 1:2B 2:4B 3:8B
- db_en  in  1  data request, held until completed
- db_write  in  1  1 = store
- db_wdata  in  64  store data
- db_ready  in  1  core accepts data response
- db_rdata  out  64  load data
- db_valid  out  1  data response held, or port not busy
- db_acc_err  out  1  access fault, qualified by db_valid
- mem_req_valid  out  1  downstream request
- mem_req_ready  in  1  downstream accepts request
- mem_addr  out  64  request address
- mem_size  out  2  request size
- mem_write  out  1  request is store
- mem_wdata  out  64  store data
- mem_resp_valid  in  1  one-cycle response pulse
- mem_resp_rdata  in  64  aligned doubleword containing mem_addr
- mem_resp_err  in  1  access fault

## Operation
- States: IDLE, REQ, WAIT, RESP. Grant owner register gnt ∈ {GNT_I, GNT_D}.
- IDLE: if any en, pick winner, latch addr/size/write/wdata and gnt, go REQ. Default: db_en wins over ib_en.
- Fetch requests are issued with size=2, write=0, wdata=0.
- REQ: mem_req_valid=1 with latched fields; on mem_req_ready go WAIT.
- WAIT: on mem_resp_valid latch rdata and err, go RESP.
- RESP: granted port's valid=1; ib_rdata = latched addr[2] ? rdata[63:32] : rdata[31:0]; db_rdata = full 64 bits unmodified. On granted port's ready go IDLE.
- Non-granted port: valid = !en (not busy when idle-requestless, 0 while waiting).
- Granted port in REQ/WAIT: valid=0. In IDLE both ports: valid = !en.
- en deassertion after grant has no effect; transaction completes and response is held until ready.
- mem_resp_valid outside WAIT is ignored. mem_req_ready outside REQ is ignored.
- Reset (any state): state=IDLE, gnt=GNT_I, round-robin pointer=last-granted I, mem_req_valid=0, all mem_* outputs 0, rdata/acc_err 0, ib_valid/db_valid 0 during reset, then !en after release. In-flight downstream transaction is abandoned.

## Timing
- Grant decision in IDLE cycle where en is sampled; mem_req_valid rises next cycle.
- REQ→WAIT in same cycle mem_req_ready is seen; RESP entered the cycle after mem_resp_valid.
- Minimum transfer: 4 cycles (IDLE, REQ with ready, WAIT with resp, RESP with ready). Back-to-back transfers re-arbitrate in the IDLE cycle after RESP.
- Simultaneous ib_en and db_en in IDLE: D wins (fixed priority) or per pointer (RR).
- Response outputs are registered; no combinational path from mem_resp_* to ib_*/db_*.

## Configuration
- ARB_RR_EN defined: round-robin; on a tie, grant the port not granted last; pointer updated on each grant. After reset, D wins first tie.
- ARB_RR_EN undefined: fixed priority, D always wins ties; pointer logic absent. Fetch starvation under continuous db_en accepted.

## Structure
- Shared package mem_arb_pkg: enum arb_state_e {ARB_IDLE, ARB_REQ, ARB_WAIT, ARB_RESP}, enum arb_gnt_e {GNT_I, GNT_D}, constant FETCH_SIZE = 2'd2.
- One sub-module: mem_arb_picker (combinational winner select plus registered RR pointer under ARB_RR_EN).

## Test plan
- Single fetch: ib_addr=0x8000_0004, mem returns 0x1111_2222_3333_4444 → ib_rdata=0x1111_2222, ib_valid held until ib_ready, mem_size=2.
- Tie: ib_en and db_en same cycle, db load 8B at 0x8000_1000 → D granted first, then I; with ARB_RR_EN second tie grants I first.
- Store: db_write=1, db_wdata=0xDEAD_BEEF_0000_0001, size=3 → mem_write=1, fields stable while mem_req_ready held low 5 cycles.
- Fault: mem_resp_err=1 on fetch → ib_acc_err=1 with ib_valid, db_valid stays !db_en.
- en drop: ib_en falls during WAIT → response still delivered, ib_valid=1 until ib_ready.
- Reset mid-WAIT: rst_n low → all mem_* 0, state IDLE; late mem_resp_valid after release ignored.
